// File: rtl/router_ingress_arb_pkg.sv
// ============================================================================
// router_pkg : shared types and constants for the router ingress arbiter
// Revision   : 1.0
// ============================================================================
`default_nettype none

package router_pkg;

    localparam int NUM_PORTS = 4;
    localparam int DATA_W    = 32;

    typedef enum logic [1:0] {
        PORT_N = 2'd0,
        PORT_S = 2'd1,
        PORT_E = 2'd2,
        PORT_W = 2'd3
    } port_e;

    typedef logic [DATA_W-1:0] flit_t;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] idx);
        return NUM_PORTS'(1) << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/router_ingress_arb_if.sv
// ============================================================================
// router_ingress_arb_if : ingress handshake and router-side request bus
// Revision              : 1.0
// ============================================================================
`default_nettype none

interface router_ingress_arb_if #(
    parameter int DATA_W = 32
) ();
    import router_pkg::*;

    logic [NUM_PORTS-1:0] in_valid_i;
    logic [NUM_PORTS-1:0] in_ready_o;
    logic [DATA_W-1:0]    in_data_n_i;
    logic [DATA_W-1:0]    in_data_s_i;
    logic [DATA_W-1:0]    in_data_e_i;
    logic [DATA_W-1:0]    in_data_w_i;
    logic                 busy_i;
    logic [NUM_PORTS-1:0] req_o;
    logic [DATA_W-1:0]    data_n_o;
    logic [DATA_W-1:0]    data_s_o;
    logic [DATA_W-1:0]    data_e_o;
    logic [DATA_W-1:0]    data_w_o;

    // Arbiter side
    modport slave (
        input  in_valid_i, in_data_n_i, in_data_s_i, in_data_e_i, in_data_w_i, busy_i,
        output in_ready_o, req_o, data_n_o, data_s_o, data_e_o, data_w_o
    );

    // Traffic source / router side
    modport master (
        output in_valid_i, in_data_n_i, in_data_s_i, in_data_e_i, in_data_w_i, busy_i,
        input  in_ready_o, req_o, data_n_o, data_s_o, data_e_o, data_w_o
    );

endinterface

`default_nettype wire

// File: rtl/router_ingress_arb_port_fifo.sv
// ============================================================================
// arb_port_fifo : per-port power-of-two FIFO with registered occupancy count
// Revision      : 1.0
// ============================================================================
`default_nettype none

module arb_port_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push_i,
    input  logic [DATA_W-1:0]               data_i,
    input  logic                            pop_i,
    output logic                            full_o,
    output logic                            empty_o,
    output logic [DATA_W-1:0]               head_o,
    output logic [$clog2(FIFO_DEPTH):0]     count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    assign full_o  = (count_q == CW'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/router_ingress_arb.sv
// ============================================================================
// router_ingress_arb : 4-port round-robin ingress arbiter feeding the router
//                      buffer; per-port grant counters with ROUTER_ARB_STATS_EN
// Revision           : 1.0
// ============================================================================
`default_nettype none

module router_ingress_arb #(
    parameter int DATA_W     = router_pkg::DATA_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    router_ingress_arb_if.slave      bus
`ifdef ROUTER_ARB_STATS_EN
    ,
    output logic [router_pkg::NUM_PORTS-1:0][15:0] grant_cnt_o
`endif
);
    import router_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0]    in_data [NUM_PORTS];
    logic [DATA_W-1:0]    head    [NUM_PORTS];
    logic [CW-1:0]        count   [NUM_PORTS];
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] ready;

    logic                 grant_vld;
    logic [1:0]           winner;
    logic [1:0]           ptr_q;
    logic [NUM_PORTS-1:0] req_q;
    logic [DATA_W-1:0]    data_q  [NUM_PORTS];

    assign in_data[0] = bus.in_data_n_i;
    assign in_data[1] = bus.in_data_s_i;
    assign in_data[2] = bus.in_data_e_i;
    assign in_data[3] = bus.in_data_w_i;

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            assign ready[p] = (count[p] < CW'(FIFO_DEPTH));
            assign push[p]  = bus.in_valid_i[p] && ready[p] && !full[p];

            arb_port_fifo #(
                .DATA_W     (DATA_W),
                .FIFO_DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .push_i  (push[p]),
                .data_i  (in_data[p]),
                .pop_i   (pop[p]),
                .full_o  (full[p]),
                .empty_o (empty[p]),
                .head_o  (head[p]),
                .count_o (count[p])
            );
        end
    endgenerate

    assign bus.in_ready_o = ready;

    // Round-robin search from the pointer; the first non-empty port wins.
    always_comb begin
        logic [1:0] idx;
        grant_vld = 1'b0;
        winner    = ptr_q;
        idx       = ptr_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = ptr_q + 2'(i);
            if (!grant_vld && !empty[idx] && !bus.busy_i) begin
                grant_vld = 1'b1;
                winner    = idx;
            end
        end
    end

    assign pop = grant_vld ? port_onehot(winner) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PORT_N;
            req_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                data_q[p] <= '0;
            end
        end else begin
            if (grant_vld) begin
                ptr_q <= winner + 2'd1;
            end
            req_q <= pop;
            for (int p = 0; p < NUM_PORTS; p++) begin
                data_q[p] <= pop[p] ? head[p] : '0;
            end
        end
    end

    assign bus.req_o    = req_q;
    assign bus.data_n_o = data_q[0];
    assign bus.data_s_o = data_q[1];
    assign bus.data_e_o = data_q[2];
    assign bus.data_w_o = data_q[3];

`ifdef ROUTER_ARB_STATS_EN
    logic [15:0] grant_cnt_q [NUM_PORTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                grant_cnt_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (pop[p] && (grant_cnt_q[p] != 16'hFFFF)) begin
                    grant_cnt_q[p] <= grant_cnt_q[p] + 16'd1;
                end
            end
        end
    end

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stats
            assign grant_cnt_o[p] = grant_cnt_q[p];
        end
    endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_router_ingress_arb.sv
// ============================================================================
// tb_router_ingress_arb : scoreboard bench for the round-robin ingress arbiter
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_router_ingress_arb;
    import router_pkg::*;

    localparam int FD = 2;

    typedef struct {
        logic [3:0]   ready_exp;
        logic [3:0]   ready_act;
        logic [3:0]   req;
        logic [127:0] lanes;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    router_ingress_arb_if #(.DATA_W(32)) bus ();

`ifdef ROUTER_ARB_STATS_EN
    logic [3:0][15:0] grant_cnt;
`endif

    router_ingress_arb #(
        .DATA_W     (32),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ROUTER_ARB_STATS_EN
        ,
        .grant_cnt_o (grant_cnt)
`endif
    );

    logic [31:0] din [4];
    assign bus.in_data_n_i = din[0];
    assign bus.in_data_s_i = din[1];
    assign bus.in_data_e_i = din[2];
    assign bus.in_data_w_i = din[3];

    exp_t        exp_q [$];
    logic [31:0] mq [4][$];
    int          ptr_m;
    logic [3:0]  acc_m;
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic [127:0] lanes_act();
        return {bus.data_w_o, bus.data_e_o, bus.data_s_o, bus.data_n_o};
    endfunction

    task automatic model_clear();
        for (int p = 0; p < 4; p++) mq[p].delete();
        exp_q.delete();
        ptr_m = 0;
        acc_m = '0;
    endtask

    // One clock: predict from the model, push the expectation, advance.
    task automatic tick();
        exp_t e;
        int   w;
        int   idx;
        e.ready_act = bus.in_ready_o;
        for (int p = 0; p < 4; p++) e.ready_exp[p] = (mq[p].size() < FD);
        w = -1;
        if (!bus.busy_i) begin
            for (int i = 0; i < 4; i++) begin
                idx = (ptr_m + i) % 4;
                if (w < 0 && mq[idx].size() > 0) w = idx;
            end
        end
        e.req   = '0;
        e.lanes = '0;
        acc_m   = '0;
        if (w >= 0) begin
            e.req[w] = 1'b1;
            e.lanes[w*32 +: 32] = mq[w].pop_front();
            ptr_m = (w + 1) % 4;
        end
        for (int p = 0; p < 4; p++) begin
            if (bus.in_valid_i[p] && e.ready_exp[p]) begin
                mq[p].push_back(din[p]);
                acc_m[p] = 1'b1;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.in_valid_i = '0;
        bus.busy_i     = 1'b0;
        rst_n          = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.in_valid_i = '0;
        bus.busy_i     = 1'b0;
        for (int p = 0; p < 4; p++) din[p] = '0;
        rst_n = 1'b0;
        model_clear();
        #12;
        n_tests += 2;
        if (bus.req_o !== 4'b0000) begin
            n_fail++; $display("FAIL reset_req: got %b want 0000", bus.req_o);
        end
        if (lanes_act() !== 128'd0) begin
            n_fail++; $display("FAIL reset_lanes: got %h want 0", lanes_act());
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready_o !== 4'b1111) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1111", bus.in_ready_o);
        end
    endtask

    task automatic test_single_n();
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            din[0] = 32'hA5A5_0001;
            bus.in_valid_i = (c == 0) ? 4'b0001 : 4'b0000;
            tick();
            e = exp_q.pop_front();
            n_tests += 3;
            if (e.ready_act !== e.ready_exp) begin
                n_fail++; $display("FAIL single_ready c=%0d: got %b want %b", c, e.ready_act, e.ready_exp);
            end
            if (bus.req_o !== e.req) begin
                n_fail++; $display("FAIL single_req c=%0d: got %b want %b", c, bus.req_o, e.req);
            end
            if (lanes_act() !== e.lanes) begin
                n_fail++; $display("FAIL single_lanes c=%0d: got %h want %h", c, lanes_act(), e.lanes);
            end
            if (c == 1) begin
                n_tests += 2;
                if (bus.req_o !== 4'b0001) begin
                    n_fail++; $display("FAIL single_req_abs: got %b want 0001", bus.req_o);
                end
                if (lanes_act() !== {96'd0, 32'hA5A5_0001}) begin
                    n_fail++; $display("FAIL single_data_abs: got %h want A5A50001 on N only", lanes_act());
                end
            end
        end
    endtask

    task automatic test_all_ports();
        exp_t        e;
        int          seq [4];
        int          k;
        logic [3:0]  want;
        apply_reset();
        k = 0;
        for (int p = 0; p < 4; p++) seq[p] = 0;
        for (int c = 0; c < 28; c++) begin
            for (int p = 0; p < 4; p++) din[p] = 32'h1000_0000 * (p + 1) + 32'(seq[p]);
            bus.in_valid_i = (c < 16) ? 4'b1111 : 4'b0000;
            tick();
            for (int p = 0; p < 4; p++) if (acc_m[p]) seq[p]++;
            e = exp_q.pop_front();
            n_tests += 3;
            if (e.ready_act !== e.ready_exp) begin
                n_fail++; $display("FAIL rr_ready c=%0d: got %b want %b", c, e.ready_act, e.ready_exp);
            end
            if (bus.req_o !== e.req) begin
                n_fail++; $display("FAIL rr_req c=%0d: got %b want %b", c, bus.req_o, e.req);
            end
            if (lanes_act() !== e.lanes) begin
                n_fail++; $display("FAIL rr_lanes c=%0d: got %h want %h", c, lanes_act(), e.lanes);
            end
            if (bus.req_o !== 4'b0000 && k < 8) begin
                want = 4'b0001 << (k % 4);
                n_tests++;
                if (bus.req_o !== want) begin
                    n_fail++; $display("FAIL rr_order k=%0d: got %b want %b", k, bus.req_o, want);
                end
                k++;
            end
        end
        n_tests++;
        if (k < 8) begin
            n_fail++; $display("FAIL rr_grants: got %0d want >=8", k);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   seq;
        int   e_grants;
        apply_reset();
        seq = 0;
        e_grants = 0;
        bus.busy_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            din[2] = 32'hEEEE_0000 + 32'(seq);
            bus.in_valid_i = (seq < 3) ? 4'b0100 : 4'b0000;
            if (c == 3) bus.busy_i = 1'b0;
            tick();
            if (acc_m[2]) seq++;
            e = exp_q.pop_front();
            n_tests += 3;
            if (e.ready_act !== e.ready_exp) begin
                n_fail++; $display("FAIL b2b_ready c=%0d: got %b want %b", c, e.ready_act, e.ready_exp);
            end
            if (bus.req_o !== e.req) begin
                n_fail++; $display("FAIL b2b_req c=%0d: got %b want %b", c, bus.req_o, e.req);
            end
            if (lanes_act() !== e.lanes) begin
                n_fail++; $display("FAIL b2b_lanes c=%0d: got %h want %h", c, lanes_act(), e.lanes);
            end
            if (bus.req_o === 4'b0100) e_grants++;
            if (c == 2) begin
                n_tests += 2;
                if (bus.in_ready_o[2] !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_full: in_ready_o[2]=%b want 0", bus.in_ready_o[2]);
                end
                if (seq != 2) begin
                    n_fail++; $display("FAIL b2b_accepted: got %0d want 2", seq);
                end
            end
        end
        n_tests++;
        if (e_grants != 3) begin
            n_fail++; $display("FAIL b2b_issued: got %0d want 3", e_grants);
        end
    endtask

    task automatic test_busy_pulse();
        exp_t       e;
        int         seq [4];
        int         gaps;
        logic       after_gap;
        logic [3:0] prev;
        apply_reset();
        gaps = 0;
        after_gap = 1'b0;
        prev = '0;
        for (int p = 0; p < 4; p++) seq[p] = 0;
        for (int c = 0; c < 32; c++) begin
            for (int p = 0; p < 4; p++) din[p] = 32'hB000_0000 + 32'h0100_0000 * p + 32'(seq[p]);
            bus.in_valid_i = (c < 20) ? 4'b1111 : 4'b0000;
            bus.busy_i     = (c == 10);
            tick();
            for (int p = 0; p < 4; p++) if (acc_m[p]) seq[p]++;
            e = exp_q.pop_front();
            n_tests += 3;
            if (e.ready_act !== e.ready_exp) begin
                n_fail++; $display("FAIL pulse_ready c=%0d: got %b want %b", c, e.ready_act, e.ready_exp);
            end
            if (bus.req_o !== e.req) begin
                n_fail++; $display("FAIL pulse_req c=%0d: got %b want %b", c, bus.req_o, e.req);
            end
            if (lanes_act() !== e.lanes) begin
                n_fail++; $display("FAIL pulse_lanes c=%0d: got %h want %h", c, lanes_act(), e.lanes);
            end
            if (c >= 2 && c < 20) begin
                if (bus.req_o === 4'b0000) begin
                    gaps++;
                    after_gap = 1'b1;
                end else begin
                    if (after_gap) begin
                        n_tests++;
                        if (bus.req_o !== {prev[2:0], prev[3]}) begin
                            n_fail++; $display("FAIL pulse_ptr: got %b want %b", bus.req_o, {prev[2:0], prev[3]});
                        end
                        after_gap = 1'b0;
                    end
                    prev = bus.req_o;
                end
            end
        end
        n_tests += 2;
        if (gaps != 1) begin
            n_fail++; $display("FAIL pulse_gaps: got %0d want 1", gaps);
        end
        if (exp_q.size() != 0 || mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() != 0) begin
            n_fail++; $display("FAIL pulse_drain: model residue %0d want 0", mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size());
        end
    endtask

    task automatic test_reset_full();
        exp_t e;
        apply_reset();
        bus.busy_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            for (int p = 0; p < 4; p++) din[p] = 32'hC000_0000 + 32'h10 * p + 32'(c);
            bus.in_valid_i = (c < 3) ? 4'b1111 : 4'b0000;
            if (c == 4) bus.busy_i = 1'b0;
            tick();
            e = exp_q.pop_front();
            n_tests += 2;
            if (e.ready_act !== e.ready_exp) begin
                n_fail++; $display("FAIL rf_ready c=%0d: got %b want %b", c, e.ready_act, e.ready_exp);
            end
            if (bus.req_o !== e.req) begin
                n_fail++; $display("FAIL rf_req c=%0d: got %b want %b", c, bus.req_o, e.req);
            end
        end
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        n_tests += 2;
        if (bus.req_o !== 4'b0000) begin
            n_fail++; $display("FAIL rf_async_req: got %b want 0000", bus.req_o);
        end
        if (lanes_act() !== 128'd0) begin
            n_fail++; $display("FAIL rf_async_lanes: got %h want 0", lanes_act());
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready_o !== 4'b1111) begin
            n_fail++; $display("FAIL rf_ready_after: got %b want 1111", bus.in_ready_o);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (bus.req_o !== e.req || lanes_act() !== e.lanes) begin
                n_fail++; $display("FAIL rf_stale c=%0d: req %b lanes %h want %b %h", c, bus.req_o, lanes_act(), e.req, e.lanes);
            end
        end
    endtask

`ifdef ROUTER_ARB_STATS_EN
    task automatic test_stats();
        exp_t e;
        int   w_grants;
        apply_reset();
        w_grants = 0;
        #1;
        n_tests++;
        if (grant_cnt !== '0) begin
            n_fail++; $display("FAIL stats_reset: got %h want 0", grant_cnt);
        end
        din[3] = 32'h5757_0000;
        bus.in_valid_i = 4'b1000;
        for (int c = 0; c < 70010; c++) begin
            tick();
            e = exp_q.pop_front();
            if (e.req[3]) w_grants++;
            if (c == 100) begin
                n_tests++;
                if (grant_cnt[3] !== 16'(w_grants)) begin
                    n_fail++; $display("FAIL stats_mid: got %0d want %0d", grant_cnt[3], w_grants);
                end
            end
        end
        bus.in_valid_i = '0;
        n_tests += 2;
        if (grant_cnt[3] !== 16'hFFFF) begin
            n_fail++; $display("FAIL stats_sat: got %h want FFFF", grant_cnt[3]);
        end
        if (grant_cnt[2:0] !== '0) begin
            n_fail++; $display("FAIL stats_others: got %h want 0", grant_cnt[2:0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_n();
        test_all_ports();
        test_back_to_back();
        test_busy_pulse();
        test_reset_full();
`ifdef ROUTER_ARB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/router_ingress_arb.md
# router_ingress_arb

Ingress arbiter that sits directly upstream of the 64-deep router buffer and drives its `req_i` / `data_*_i` inputs. It accepts 32-bit flits from four ports (N, S, E, W) over valid/ready handshakes and buffers each port in a 2-entry FIFO. Each cycle it grants one port round-robin, presenting a one-hot request with data on the matching lane. Issue halts while the router asserts `busy_o`, so fairness replaces the router's fixed N>S>E>W priority.

## Interface
Parameters:
- `DATA_W`, 32, flit width
- `FIFO_DEPTH`, 2, entries per port FIFO (power of two, ≥2)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid_i`  in  4  per-port flit valid, bit0=N, 1=S, 2=E, 3=W
- `in_ready_o`  out  4  per-port FIFO not full
- `in_data_n_i` / `in_data_s_i` / `in_data_e_i` / `in_data_w_i`  in  DATA_W each  port flits
- `busy_i`  in  1  router `busy_o`; 1 = stop issuing
- `req_o`  out  4  one-hot or zero, to router `req_i`
- `data_n_o` / `data_s_o` / `data_e_o` / `data_w_o`  out  DATA_W each  to router `data_*_i`; only the granted lane is non-zero
- `grant_cnt_o`  out  4×16  per-port grant counters (present only with `ROUTER_ARB_STATS_EN`)

## Operation
- Reset: all FIFOs empty, `in_ready_o`=4'b1111 after reset release, `req_o`=0, all `data_*_o`=0, RR pointer=N (port 0), counters=0. Reset mid-operation discards all buffered flits immediately.
- Push: port p pushes when `in_valid_i[p] && in_ready_o[p]`. `in_ready_o[p]` = (count[p] < FIFO_DEPTH), derived from registered count, combinational to the port.
- Arbitration runs each cycle when `!busy_i` and any FIFO is non-empty. Search order starts at pointer, wraps 3→0. First non-empty port wins. Pointer ← winner+1 (mod 4). No grant: pointer holds.
- Grant pops the winner's FIFO head. Next edge registers `req_o`=onehot(winner) and the head onto that lane; other lanes are 0.
- No grant (busy or all empty): `req_o`=0, all lanes 0.
- Simultaneous push and pop on the same port: count unchanged; FIFO pointers wrap mod FIFO_DEPTH.
- FIFOs preserve order per port. There is no ordering across ports.
- `busy_i` is sampled raw with no synchronizer, same clock domain.

## Timing
- Flit accepted at edge t becomes eligible at t+1 and appears on `req_o` at earliest cycle t+1→t+2 (registered at edge t+1). Router captures it at the following edge.
- Throughput: one flit per cycle aggregate. The pop at edge t frees `in_ready_o` in cycle t+1.
- Backpressure slack: `busy_i` is observed one cycle late and `req_o` is registered. At most 2 flits issue after the router count reaches 60. This stays within the 4-entry headroom.
- `busy_i` high in cycle c: no grant at edge c, so `req_o`=0 in cycle c+1.

## Configuration
- `ROUTER_ARB_STATS_EN` defined: `grant_cnt_o` exists. Counter p increments on every grant to p, saturates at 16'hFFFF, and resets to 0.
- Not defined: the port and counters are absent, and arbitration behaviour is identical.

## Structure
- Shared package `router_pkg`:
  - `NUM_PORTS`=4, `DATA_W`=32
  - enum `port_e` {PORT_N=0, PORT_S, PORT_E, PORT_W}
  - type `flit_t` = logic[DATA_W-1:0]
- Sub-module `arb_port_fifo`: one per port. Holds `FIFO_DEPTH` entries with push/pop/full/empty/head and a count width of clog2(FIFO_DEPTH)+1.
- Top holds the RR pointer, grant logic, output registers and stats.

## Test plan
- Reset, then a single N flit 32'hA5A5_0001 → `req_o`=4'b0001 and `data_n_o`=32'hA5A5_0001 two cycles after acceptance; other lanes 0.
- All four ports valid continuously, `busy_i`=0 → `req_o` cycles 0001,0010,0100,1000,0001… with per-port data in order.
- Port E only, 3 back-to-back flits, busy held high → 2 accepted, `in_ready_o[2]`=0. Busy drops → both flits issue in order and the third is accepted.
- `busy_i` pulses high for one cycle mid-stream → exactly one `req_o`=0 gap, no flit lost or duplicated, RR pointer unchanged.
- Assert `rst_n` low with all FIFOs full → outputs 0 asynchronously; after release `in_ready_o`=1111 and no stale flit is issued.
- With `ROUTER_ARB_STATS_EN`: 70000 grants to W → `grant_cnt_o[W]`=16'hFFFF; other counters unchanged.
